// File: rtl/semeion_inference_sequencer.sv
// Sequencer for one Semeion digit inference: accepts an image, drives layer 1
// then layer 2, and returns the class index, with a timeout watchdog and latency counter.
module semeion_inference_sequencer #(
  parameter int IMG_WIDTH      = 256,
  parameter int CLASS_WIDTH    = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH      = 13
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   img_valid,
  input  logic [IMG_WIDTH-1:0]   img_data,
  output logic                   img_ready,
  output logic [IMG_WIDTH-1:0]   l1_input,
  output logic                   l1_load,
  input  logic                   l1_done,
  output logic                   l2_load,
  input  logic                   l2_done,
  input  logic [CLASS_WIDTH-1:0] l2_class,
  output logic                   res_valid,
  output logic [CLASS_WIDTH-1:0] res_class,
  input  logic                   res_ready,
  output logic                   busy,
  output logic                   err_timeout,
  output logic [CNT_WIDTH-1:0]   latency,
  output logic [2:0]             dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid & ready are
  // both high; the offering side holds its data stable until that edge.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    L1_START = 3'd1,
    L1_WAIT  = 3'd2,
    L2_START = 3'd3,
    L2_WAIT  = 3'd4,
    RESULT   = 3'd5,
    ERR      = 3'd6
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TIMER_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] timer;
  logic                 l1_done_q, l2_done_q;
  logic                 l1_rise_q, l2_rise_q;
  logic                 timed_out;

  assign timed_out = (timer == TIMER_LAST);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    img_ready = 1'b0;
    l1_load   = 1'b0;
    l2_load   = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        img_ready = 1'b1;
        if (img_valid) state_nxt = L1_START;
      end
      L1_START: begin
        l1_load   = 1'b1;
        state_nxt = L1_WAIT;
      end
      // A done edge outranks a timeout landing in the same cycle.
      L1_WAIT: begin
        if (l1_rise_q)      state_nxt = L2_START;
        else if (timed_out) state_nxt = ERR;
      end
      L2_START: begin
        l2_load   = 1'b1;
        state_nxt = L2_WAIT;
      end
      L2_WAIT: begin
        if (l2_rise_q)      state_nxt = RESULT;
        else if (timed_out) state_nxt = ERR;
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= '0;
      l1_done_q   <= 1'b0;
      l2_done_q   <= 1'b0;
      l1_rise_q   <= 1'b0;
      l2_rise_q   <= 1'b0;
      l1_input    <= '0;
      res_class   <= '0;
      err_timeout <= 1'b0;
      latency     <= '0;
    end else begin
      state     <= state_nxt;
      // Done levels may stay high across runs, so only a fresh rising edge counts.
      l1_done_q <= l1_done;
      l2_done_q <= l2_done;
      l1_rise_q <= l1_done & ~l1_done_q;
      l2_rise_q <= l2_done & ~l2_done_q;

      if (state == L1_START || state == L2_START) timer <= '0;
      else if (state == L1_WAIT || state == L2_WAIT) timer <= timer + CNT_WIDTH'(1);

      if (state == IDLE && img_valid) begin
        l1_input    <= img_data;
        err_timeout <= 1'b0;
        latency     <= '0;
      end else if (state == L1_START || state == L1_WAIT ||
                   state == L2_START || state == L2_WAIT) begin
        if (latency != '1) latency <= latency + CNT_WIDTH'(1);
      end

      if (state == L2_WAIT && l2_rise_q) res_class <= l2_class;
      if (state == ERR) err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_semeion_inference_sequencer.sv
// Directed bench for semeion_inference_sequencer: full inference, result
// back-pressure, timeout, held done level, async reset and back-to-back images.
module tb_semeion_inference_sequencer;

  localparam int IW = 256;
  localparam int CW = 4;
  localparam int NW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          img_valid;
  logic [IW-1:0] img_data;
  logic          img_ready;
  logic [IW-1:0] l1_input;
  logic          l1_load;
  logic          l1_done;
  logic          l2_load;
  logic          l2_done;
  logic [CW-1:0] l2_class;
  logic          res_valid;
  logic [CW-1:0] res_class;
  logic          res_ready;
  logic          busy;
  logic          err_timeout;
  logic [NW-1:0] latency;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int l1_cnt   = 0;
  int l2_cnt   = 0;
  int res_cnt  = 0;

  semeion_inference_sequencer dut (
    .clk(clk), .reset(reset),
    .img_valid(img_valid), .img_data(img_data), .img_ready(img_ready),
    .l1_input(l1_input), .l1_load(l1_load), .l1_done(l1_done),
    .l2_load(l2_load), .l2_done(l2_done), .l2_class(l2_class),
    .res_valid(res_valid), .res_class(res_class), .res_ready(res_ready),
    .busy(busy), .err_timeout(err_timeout), .latency(latency),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Pulse monitors, sampled mid-cycle
  always @(negedge clk) begin
    if (l1_load)   l1_cnt++;
    if (l2_load)   l2_cnt++;
    if (res_valid) res_cnt++;
  end

  task automatic check(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // which: 0 l1_load, 1 l2_load, 2 res_valid, 3 err_timeout
  task automatic wait_until(input int which, input int budget, input string tag, output int cycles);
    logic hit;
    hit = 1'b0;
    cycles = 0;
    while (!hit && cycles < budget) begin
      tick();
      cycles++;
      case (which)
        0: hit = l1_load;
        1: hit = l2_load;
        2: hit = res_valid;
        default: hit = err_timeout;
      endcase
    end
    check(tag, IW'(hit), IW'(1));
  endtask

  task automatic accept(input logic [IW-1:0] img);
    img_valid = 1'b1;
    img_data  = img;
    tick();
    img_valid = 1'b0;
  endtask

  logic [IW-1:0] img_a5, img_3c, img_0f, img_5a, img_x, img_y;
  int cyc;
  int l1_before, l2_before, res_before;

  initial begin
    img_a5 = {32{8'hA5}};
    img_3c = {32{8'h3C}};
    img_0f = {32{8'h0F}};
    img_5a = {32{8'h5A}};
    img_x  = {16{16'h1234}};
    img_y  = {16{16'hBEEF}};

    reset = 1'b0; img_valid = 1'b0; img_data = '0;
    l1_done = 1'b0; l2_done = 1'b0; l2_class = '0; res_ready = 1'b0;
    tick(); tick();
    check("rst_busy", IW'(busy), 0);
    check("rst_img_ready", IW'(img_ready), 1);
    check("rst_res_valid", IW'(res_valid), 0);
    check("rst_l1_input", l1_input, 0);
    check("rst_latency", IW'(latency), 0);
    check("rst_err", IW'(err_timeout), 0);
    check("rst_loads", IW'({l1_load, l2_load}), 0);
    reset = 1'b1;
    tick();

    // 1: full inference, done edges at load+10 and load+6
    accept(img_a5);
    check("t1_l1_load", IW'(l1_load), 1);
    check("t1_l1_input", l1_input, img_a5);
    check("t1_img_ready_busy", IW'(img_ready), 0);
    repeat (10) tick();
    l1_done = 1'b1;
    wait_until(1, 20, "t1_l2_load_seen", cyc);
    repeat (6) tick();
    l2_done = 1'b1; l2_class = 4'd7;
    wait_until(2, 20, "t1_res_valid_seen", cyc);
    check("t1_res_class", IW'(res_class), 7);
    check("t1_latency", IW'(latency), 20);
    check("t1_err", IW'(err_timeout), 0);
    check("t1_l1_pulses", IW'(l1_cnt), 1);
    check("t1_l2_pulses", IW'(l2_cnt), 1);

    // 2: result back-pressure
    l2_class = 4'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_res_valid_hold", IW'(res_valid), 1);
      check("t2_res_class_hold", IW'(res_class), 7);
      check("t2_img_ready_low", IW'(img_ready), 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t2_img_ready_after", IW'(img_ready), 1);
    check("t2_res_valid_after", IW'(res_valid), 0);
    l2_done = 1'b0;

    // 4: l1_done still high from the previous run
    l2_before = l2_cnt;
    accept(img_3c);
    repeat (20) tick();
    check("t4_no_false_l2", IW'(l2_cnt), IW'(l2_before));
    check("t4_state_l1_wait", IW'(dbg_state), 2);
    l1_done = 1'b0;
    tick();
    l1_done = 1'b1;
    wait_until(1, 10, "t4_l2_load_after_edge", cyc);
    l2_done = 1'b1; l2_class = 4'd3;
    wait_until(2, 10, "t4_res_valid_seen", cyc);
    check("t4_res_class", IW'(res_class), 3);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    l1_done = 1'b0; l2_done = 1'b0;
    tick();

    // 3: l1_done never rises -> timeout
    l2_before = l2_cnt; res_before = res_cnt;
    accept(img_0f);
    wait_until(3, 5000, "t3_err_seen", cyc);
    check("t3_timeout_cycles", IW'(cyc), 4098);
    check("t3_err", IW'(err_timeout), 1);
    check("t3_idle", IW'(img_ready), 1);
    check("t3_no_l2_load", IW'(l2_cnt), IW'(l2_before));
    check("t3_no_result", IW'(res_cnt), IW'(res_before));
    // next image clears the error; same-cycle done edges give minimum latency
    accept(img_5a);
    check("t3_err_cleared", IW'(err_timeout), 0);
    l1_done = 1'b1;
    tick(); tick();
    check("t3_min_l2_load", IW'(l2_load), 1);
    l2_done = 1'b1; l2_class = 4'd9;
    tick(); tick();
    check("t3_min_res_valid", IW'(res_valid), 1);
    check("t3_min_latency", IW'(latency), 4);
    check("t3_min_class", IW'(res_class), 9);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    l1_done = 1'b0; l2_done = 1'b0;
    tick();

    // 5: async reset in L2_WAIT
    accept(img_a5);
    l1_done = 1'b1;
    tick(); tick(); tick();
    check("t5_in_l2_wait", IW'(dbg_state), 4);
    #2 reset = 1'b0;
    #1;
    check("t5_busy", IW'(busy), 0);
    check("t5_res_valid", IW'(res_valid), 0);
    check("t5_img_ready", IW'(img_ready), 1);
    tick();
    reset = 1'b1;
    l1_before = l1_cnt; l2_before = l2_cnt;
    repeat (5) tick();
    check("t5_no_l1_pulse", IW'(l1_cnt), IW'(l1_before));
    check("t5_no_l2_pulse", IW'(l2_cnt), IW'(l2_before));
    l1_done = 1'b0;
    tick();

    // 6: back-to-back images, res_ready tied high
    res_ready = 1'b1;
    img_valid = 1'b1; img_data = img_x;
    tick();
    img_data = img_y;
    check("t6_first_load", IW'(l1_load), 1);
    tick();
    l1_done = 1'b1;
    tick();
    check("t6_hold_c2", l1_input, img_x);
    tick();
    check("t6_l2_load", IW'(l2_load), 1);
    l1_done = 1'b0;
    tick();
    l2_done = 1'b1; l2_class = 4'd2;
    tick();
    check("t6_hold_c5", l1_input, img_x);
    tick();
    check("t6_res_valid", IW'(res_valid), 1);
    check("t6_res_class", IW'(res_class), 2);
    check("t6_latency", IW'(latency), 6);
    tick();
    check("t6_accept_cycle", IW'(img_ready), 1);
    check("t6_hold_accept", l1_input, img_x);
    tick();
    img_valid = 1'b0;
    check("t6_second_load", IW'(l1_load), 1);
    check("t6_second_input", l1_input, img_y);
    l2_done = 1'b0;
    tick();
    l1_done = 1'b1;
    wait_until(1, 10, "t6_second_l2_load", cyc);
    l2_done = 1'b1; l2_class = 4'd5;
    wait_until(2, 10, "t6_second_res", cyc);
    check("t6_second_class", IW'(res_class), 5);
    tick();
    check("t6_back_idle", IW'(dbg_state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
